// File: rtl/count_capture.sv
// Event-triggered capture of a free-running count into a show-ahead FIFO with sticky overflow.
// Optional macro CAPTURE_FILTER_EN adds a 2-sample glitch filter on event_in.
module count_capture #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [W-1:0]             count_in,
  input  logic                     event_in,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [W-1:0]             cap_data,
  output logic [$clog2(DEPTH):0]   cap_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic          evq;
  logic          evq_next;
  logic          capture;
  logic          pop;
  logic          push;
  logic          full;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [W-1:0]  mem [DEPTH];

`ifdef CAPTURE_FILTER_EN
  logic ev_s;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) ev_s <= 1'b0;
    else       ev_s <= event_in;
  end

  // evq only follows event_in once two consecutive samples agree
  assign evq_next = (event_in == ev_s) ? event_in : evq;
`else
  assign evq_next = event_in;
`endif

  assign capture   = evq_next & ~evq;
  assign full      = (cap_level == FULL_LEVEL);
  assign cap_valid = (cap_level != '0);
  assign pop       = cap_valid & cap_ready;
  assign push      = capture & (~full | pop);
  assign cap_data  = cap_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      evq       <= 1'b0;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cap_level <= '0;
    end else begin
      evq <= evq_next;
      if (capture && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      // A simultaneous push and pop leaves the occupancy unchanged
      case ({push, pop})
        2'b10:   cap_level <= cap_level + 1'b1;
        2'b01:   cap_level <= cap_level - 1'b1;
        default: cap_level <= cap_level;
      endcase
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= count_in;
    end
  end

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 SHALL have parameter W, default 8, width of the captured count.
REQ-002 SHALL have parameter DEPTH, default 4, number of capture FIFO entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port count_in  input  W  free-running up-count from the upstream counter (changes on the falling clock edge).
REQ-006 SHALL have port event_in  input  1  synchronous event strobe; a rising edge requests a capture.
REQ-007 SHALL have port cap_valid  output  1  FIFO non-empty; cap_data holds the oldest entry.
REQ-008 SHALL have port cap_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port cap_data  output  W  head entry of the FIFO (show-ahead).
REQ-010 SHALL have port cap_level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-012 SHALL keep an internal qualified event level evq; in unfiltered mode, evq <= event_in on each rising edge.
REQ-013 SHALL detect a capture when the value about to load into evq is 1 and evq is currently 0; the push occurs on that same rising edge.
REQ-014 SHALL write count_in as sampled on the push edge; count_in is stable at the rising edge.
REQ-015 SHALL assert cap_valid on the rising edge of a push into an empty FIFO (zero-cycle latency to visibility after the push edge).
REQ-016 SHALL pop the head entry on a rising edge where cap_valid=1 and cap_ready=1; cap_ready while cap_valid=0 has no effect.
REQ-017 SHALL accept a push when cap_level<DEPTH, or when cap_level=DEPTH and a pop occurs on the same edge (level stays DEPTH).
REQ-018 SHALL drop the push and set overflow=1 when cap_level=DEPTH and no pop occurs on that edge; FIFO contents are unchanged.
REQ-019 SHALL keep overflow set until clear; it is never cleared by pops.
REQ-020 SHALL, on a push and pop on the same edge with 0<cap_level<DEPTH, leave cap_level unchanged and advance both pointers.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH, and SHALL derive cap_level from a separate counter or extended pointers, never ambiguously.
REQ-022 SHALL capture count_in values without modification, including wrap from 2^W-1 to 0; no timestamp arithmetic.
REQ-023 SHALL treat a level held high as a single capture; a new capture requires evq to return to 0.

Reset
REQ-024 SHALL, while clear=1, force immediately and asynchronously: cap_valid=0, cap_level=0, cap_data=0, overflow=0, evq=0, pointers=0, all FIFO entries=0.
REQ-025 SHALL discard in-flight captures and stored entries on clear mid-operation; no push or pop occurs on an edge with clear=1.
REQ-026 SHALL not detect a capture on the first edge after clear deasserts unless event_in=1 (evq restarts at 0).

Configuration
REQ-027 SHALL support macro CAPTURE_FILTER_EN; when defined, it adds a 2-sample glitch filter: register ev_s <= event_in, and evq loads event_in only when event_in==ev_s, otherwise it holds.
REQ-028 SHALL, with CAPTURE_FILTER_EN defined, ignore a 1-cycle event pulse and capture a 2-cycle pulse at its second high edge (one cycle later than unfiltered); ev_s resets to 0.
REQ-029 SHALL, without CAPTURE_FILTER_EN, have no ev_s register and behave exactly as REQ-012/013.

Verification
REQ-030 SHALL verify basic capture: clear 15 ns; event_in rises while count_in=5 -> cap_valid=1, cap_data=5, cap_level=1; cap_ready 1 cycle -> cap_valid=0.
REQ-031 SHALL verify full/overflow: 5 separate events at counts 10, 12, 14, 16, 18 with cap_ready=0 -> level=4, overflow=1, pops yield 10, 12, 14, 16.
REQ-032 SHALL verify simultaneous push/pop at full: level=4, cap_ready=1 on an event edge -> level stays 4, overflow stays 0, new value at tail.
REQ-033 SHALL verify wrap: event at count_in=255, then at 0 -> entries 255, 0 in order; 6 push/pop cycles exercise pointer wrap with order preserved.
REQ-034 SHALL verify clear mid-operation: level=3, overflow=1, then clear pulse -> all outputs 0 immediately, before the next clock edge.
REQ-035 SHALL verify the filter: with CAPTURE_FILTER_EN defined, a 1-cycle pulse -> no capture, and a 3-cycle pulse -> exactly one capture, one cycle later than without the macro.
